gate_checker: RTL and testbench

- Self-test exerciser for the seven-output basic-gate block (and, or, not, nand, nor, xor, xnor); it sits on the opposite end of that block's interface.
- Drives the gate block's a/b inputs through all four combinations and waits a programmable settle time.
- Samples the seven gate outputs and compares them against internally computed expected values.
- Reports pass/fail, a per-output failure mask, the first failing vector and a mismatch count through a start/done handshake.

---
 rtl/gate_checker.sv | 137 +++++++++++++
 tb/tb_gate_checker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// gate_checker: self-test exerciser that walks a basic-gate block through all a/b combinations and scores its seven outputs
module gate_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       in_and,
    input  logic       in_or,
    input  logic       in_not,
    input  logic       in_nand,
    input  logic       in_nor,
    input  logic       in_xor,
    input  logic       in_xnor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] first_err_vec,
    output logic       err_valid,
    output logic [4:0] err_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] mask_q, mask_d;
    logic [1:0] first_q, first_d;
    logic       ev_q, ev_d;
    logic [4:0] errc_q, errc_d;
    logic [6:0] expected, mismatch;
    logic [4:0] pop;

    assign a             = vec_q[1];
    assign b             = vec_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_mask     = mask_q;
    assign first_err_vec = first_q;
    assign err_valid     = ev_q;
    assign err_count     = errc_q;

    // Expected gate results for the vector currently driven, and how many outputs disagree
    always_comb begin
        expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        mismatch = {in_xnor, in_xor, in_nor, in_nand, in_not, in_or, in_and} ^ expected;
        pop = 5'd0;
        for (int i = 0; i < 7; i++) pop = pop + 5'(mismatch[i]);
    end

    // Sequencer: start accept, per-vector settle, one-cycle scoring, and the result handoff
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        first_d = first_q;
        ev_d    = ev_q;
        errc_d  = errc_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETTLE;
                vec_d   = 2'd0;
                cnt_d   = RELOAD;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
                mask_d  = 7'd0;
                first_d = 2'd0;
                ev_d    = 1'b0;
                errc_d  = 5'd0;
            end
            SETTLE: if (cnt_q == 4'd0) state_d = CHECK; else cnt_d = cnt_q - 4'd1;
            CHECK: begin
                mask_d = mask_q | mismatch;
                errc_d = errc_q + pop;
                if (mismatch != 7'd0 && !ev_q) begin
                    first_d = vec_q;
                    ev_d    = 1'b1;
                end
                if (vec_q == 2'd3) state_d = DONE;
                else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (mask_q == 7'd0);
                vec_d   = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run and drives the stimulus back to 00 at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 7'd0;
            first_q <= 2'd0;
            ev_q    <= 1'b0;
            errc_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            ev_q    <= ev_d;
            errc_q  <= errc_d;
        end
    end
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: directed checks of gate_checker against good and faulty gate models
module tb_gate_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic a, b, busy, done, pass, err_valid;
    logic [6:0] fail_mask;
    logic [1:0] first_err_vec;
    logic [4:0] err_count;
    int mode = 0;
    int checks = 0;
    int passed = 0;

    wire g_and  = a & b;
    wire g_or   = a | b;
    wire g_not  = ~a;
    wire g_nand = (mode == 2) ? 1'b1 : ~(a & b);
    wire g_nor  = ~(a | b);
    wire g_xor  = (mode == 1) ? ~(a ^ b) : (a ^ b);
    wire g_xnor = (mode == 1) ? (a ^ b) : ~(a ^ b);

    gate_checker #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .in_and(g_and), .in_or(g_or), .in_not(g_not), .in_nand(g_nand),
        .in_nor(g_nor), .in_xor(g_xor), .in_xnor(g_xnor),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .first_err_vec(first_err_vec), .err_valid(err_valid), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse start, follow the run to done, then score latency, stimulus order and results.
    // With spur set, extra start requests land while busy and in the DONE cycle, and start is left high afterwards.
    task automatic run(input int m, input bit spur, input logic exp_pass, input logic [6:0] emask,
                       input logic [4:0] ecnt, input logic [1:0] evec, input logic ev);
        int n;
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ab_vec0", {a, b}, 0);
        chk("cleared_count", err_count, 0);
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1 n++;
            start = spur && (n == 4 || n >= 12);
            if (n == 1 || n == 4 || n == 7 || n == 10) chk("ab_order", {a, b}, n / 3);
        end
        chk("latency", n, 13);
        chk("pass", pass, exp_pass);
        chk("fail_mask", fail_mask, emask);
        chk("err_count", err_count, ecnt);
        chk("first_err_vec", first_err_vec, evec);
        chk("err_valid", err_valid, ev);
        chk("busy_at_done", busy, 0);
        chk("ab_idle", {a, b}, 0);
        if (!spur) begin
            @(posedge clk);
            #1 chk("done_one_cycle", done, 0);
            chk("pass_held", pass, exp_pass);
        end
    endtask

    initial begin
        int n, dones;
        #12 rst = 1'b1;
        #1 chk("async_reset", {a, b, busy, done, pass, fail_mask, first_err_vec, err_valid, err_count}, 0);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (50) begin
            @(posedge clk);
            #1 dones += int'(done);
        end
        chk("idle_no_done", dones, 0);

        run(0, 0, 1'b1, 7'b0000000, 5'd0, 2'b00, 1'b0);
        run(1, 0, 1'b0, 7'b1100000, 5'd8, 2'b00, 1'b1);
        run(2, 0, 1'b0, 7'b0001000, 5'd1, 2'b11, 1'b1);

        run(0, 1, 1'b1, 7'b0000000, 5'd0, 2'b00, 1'b0);
        mode = 1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_pass_cleared", pass, 0);
        chk("restart_no_done", done, 0);
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1 n++;
        end
        chk("restart_latency", n, 13);
        chk("restart_mask", fail_mask, 7'b1100000);
        chk("restart_count", err_count, 8);

        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 chk("midrun_ab_before_reset", {a, b}, 2'b10);
        #2 rst = 1'b1;
        #1 chk("midrun_reset", {a, b, busy, done, pass, fail_mask, first_err_vec, err_valid, err_count}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1 dones += int'(done);
        end
        chk("midrun_no_done", dones, 0);
        run(0, 0, 1'b1, 7'b0000000, 5'd0, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
